ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 16, datapath width.
REQ-002 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ex_valid  input  1  EX holds a real instruction.
REQ-005 SHALL have port stall  input  1  hold EX/MEM contents.
REQ-006 SHALL have port flush  input  1  replace incoming instruction with bubble.
REQ-007 SHALL have ports alu_out  input  OPERAND_WIDTH, alu_zero/alu_ofl/alu_cf  input  1 each  ALU result and flags.
REQ-008 SHALL have port set_en  input  1, set_op  input  2  (00 SEQ, 01 SLT, 10 SLE, 11 SCO).
REQ-009 SHALL have ports br_en  input  1, br_cond  input  2  (00 BEQZ, 01 BNEZ, 10 BLTZ, 11 BGEZ), rs_val  input  OPERAND_WIDTH, br_target_in  input  OPERAND_WIDTH.
REQ-010 SHALL have ports store_data  input  OPERAND_WIDTH, rd  input  3, reg_wen/mem_wen/mem_ren/halt  input  1 each.
REQ-011 SHALL have outputs m_valid 1, m_result OPERAND_WIDTH, m_store_data OPERAND_WIDTH, m_rd 3, m_reg_wen 1, m_mem_wen 1, m_mem_ren 1, m_halt 1, m_br_taken 1, m_br_target OPERAND_WIDTH, m_ofl 1.

Function
REQ-012 SHALL compute lt = alu_out[MSB] XOR alu_ofl (ALU performed A minus B, signed).
REQ-013 SHALL form set value: SEQ=alu_zero; SLT=lt AND NOT alu_zero; SLE=lt OR alu_zero; SCO=alu_cf; zero-extended to OPERAND_WIDTH.
REQ-014 SHALL select result = set value when set_en, else alu_out.
REQ-015 SHALL evaluate taken = br_en AND cond: BEQZ rs_val==0; BNEZ rs_val!=0; BLTZ rs_val[MSB]; BGEZ NOT rs_val[MSB].
REQ-016 SHALL register all outputs with latency exactly one cycle from a capturing edge.
REQ-017 SHALL use states RUN, HALTED; RUN captures each edge per REQ-018..020.
REQ-018 Priority per edge: flush > stall > capture.
REQ-019 flush SHALL load bubble: m_valid, m_reg_wen, m_mem_wen, m_mem_ren, m_halt, m_br_taken, m_ofl = 0; data fields unchanged.
REQ-020 stall (no flush) SHALL hold every output register unchanged.
REQ-021 capture with ex_valid=0 SHALL load bubble; with ex_valid=1 SHALL load all fields, m_ofl = alu_ofl AND NOT set_en.
REQ-022 Capturing valid halt=1 SHALL move RUN->HALTED, m_halt=1, m_valid=1 for that cycle.
REQ-023 In HALTED, next edge SHALL clear m_valid and all enables, keep m_halt=1; all inputs including flush ignored until rst.
REQ-024 Simultaneous stall and halt in EX SHALL not transition (halt not captured).

Reset
REQ-025 rst SHALL immediately force state RUN and all outputs 0, independent of clk.
REQ-026 rst deassertion mid-stream SHALL resume capture on the first subsequent rising edge.

Structure
REQ-027 Shared package SHALL hold set_op and br_cond encodings, state enum, and OPERAND_WIDTH default.
REQ-028 One sub-module, cond_eval (combinational set/branch evaluation, REQ-012..015), SHALL be instantiated once; registers in ex_mem_stage.

Verification
REQ-029 SLT: alu_out=16'hFFFF, ofl=0, zero=0, set_en=1, set_op=01 -> next edge m_result=16'h0001.
REQ-030 Overflow SLT: alu_out=16'h7FFF, ofl=1, set_op=01 -> m_result=16'h0001; set_op=00 -> 16'h0000.
REQ-031 Branch: br_en=1, BLTZ, rs_val=16'h8000, br_target_in=16'h0040 -> m_br_taken=1, m_br_target=16'h0040; BGEZ -> m_br_taken=0.
REQ-032 stall=1 and flush=1 same edge with valid reg_wen=1 -> m_valid=0, m_reg_wen=0; stall alone 3 cycles -> outputs constant.
REQ-033 halt=1 captured -> m_halt=1, m_valid=1, next edge m_valid=0, m_halt stays 1 despite new ex_valid=1 inputs.
REQ-034 rst pulsed between clock edges while HALTED -> outputs 0 before next edge; next valid add (alu_out=16'h1234) captured normally.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// rtl/ex_mem_stage_pkg.sv - shared encodings and defaults for the EX/MEM pipeline stage
package ex_mem_stage_pkg;
  localparam int OPERAND_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    SET_SEQ = 2'b00,
    SET_SLT = 2'b01,
    SET_SLE = 2'b10,
    SET_SCO = 2'b11
  } set_op_e;

  typedef enum logic [1:0] {
    BR_BEQZ = 2'b00,
    BR_BNEZ = 2'b01,
    BR_BLTZ = 2'b10,
    BR_BGEZ = 2'b11
  } br_cond_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // What the output register bank does on the coming edge
  typedef enum logic [1:0] {
    LD_HOLD       = 2'b00,
    LD_BUBBLE     = 2'b01,
    LD_CAPTURE    = 2'b10,
    LD_HALT_DRAIN = 2'b11
  } load_e;
endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational set-on-condition result select and branch decision
module cond_eval
  import ex_mem_stage_pkg::*;
#(
  parameter int OPERAND_WIDTH = OPERAND_WIDTH_DEF
) (
  input  logic [OPERAND_WIDTH-1:0] alu_out,
  input  logic                     alu_zero,
  input  logic                     alu_ofl,
  input  logic                     alu_cf,
  input  logic                     set_en,
  input  logic [1:0]               set_op,
  input  logic                     br_en,
  input  logic [1:0]               br_cond,
  input  logic [OPERAND_WIDTH-1:0] rs_val,
  output logic [OPERAND_WIDTH-1:0] result,
  output logic                     taken
);
  logic w_lt;
  logic w_set_bit;
  logic w_cond;

  // ALU computed A-B; sign of the true difference is MSB corrected by overflow
  assign w_lt = alu_out[OPERAND_WIDTH-1] ^ alu_ofl;

  always_comb begin
    w_set_bit = 1'b0;
    case (set_op)
      SET_SEQ: w_set_bit = alu_zero;
      SET_SLT: w_set_bit = w_lt & ~alu_zero;
      SET_SLE: w_set_bit = w_lt | alu_zero;
      SET_SCO: w_set_bit = alu_cf;
      default: w_set_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (br_cond)
      BR_BEQZ: w_cond = (rs_val == '0);
      BR_BNEZ: w_cond = (rs_val != '0);
      BR_BLTZ: w_cond = rs_val[OPERAND_WIDTH-1];
      BR_BGEZ: w_cond = ~rs_val[OPERAND_WIDTH-1];
      default: w_cond = 1'b0;
    endcase
  end

  assign result = set_en ? {{(OPERAND_WIDTH-1){1'b0}}, w_set_bit} : alu_out;
  assign taken  = br_en & w_cond;
endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with flush/stall priority and halt latch
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int OPERAND_WIDTH = OPERAND_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [OPERAND_WIDTH-1:0] alu_out,
  input  logic                     alu_zero,
  input  logic                     alu_ofl,
  input  logic                     alu_cf,
  input  logic                     set_en,
  input  logic [1:0]               set_op,
  input  logic                     br_en,
  input  logic [1:0]               br_cond,
  input  logic [OPERAND_WIDTH-1:0] rs_val,
  input  logic [OPERAND_WIDTH-1:0] br_target_in,
  input  logic [OPERAND_WIDTH-1:0] store_data,
  input  logic [2:0]               rd,
  input  logic                     reg_wen,
  input  logic                     mem_wen,
  input  logic                     mem_ren,
  input  logic                     halt,
  output logic                     m_valid,
  output logic [OPERAND_WIDTH-1:0] m_result,
  output logic [OPERAND_WIDTH-1:0] m_store_data,
  output logic [2:0]               m_rd,
  output logic                     m_reg_wen,
  output logic                     m_mem_wen,
  output logic                     m_mem_ren,
  output logic                     m_halt,
  output logic                     m_br_taken,
  output logic [OPERAND_WIDTH-1:0] m_br_target,
  output logic                     m_ofl
);
  state_e                   r_state;
  state_e                   w_next_state;
  load_e                    w_load;
  logic [OPERAND_WIDTH-1:0] w_result;
  logic                     w_taken;

  cond_eval #(.OPERAND_WIDTH(OPERAND_WIDTH)) u_cond_eval (
    .alu_out  (alu_out),
    .alu_zero (alu_zero),
    .alu_ofl  (alu_ofl),
    .alu_cf   (alu_cf),
    .set_en   (set_en),
    .set_op   (set_op),
    .br_en    (br_en),
    .br_cond  (br_cond),
    .rs_val   (rs_val),
    .result   (w_result),
    .taken    (w_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_next_state;
  end

  // A halt stuck behind a stall or flush is never captured, so no transition
  always_comb begin
    w_next_state = r_state;
    w_load       = LD_HOLD;
    case (r_state)
      ST_RUN: begin
        if (flush)          w_load = LD_BUBBLE;
        else if (stall)     w_load = LD_HOLD;
        else if (!ex_valid) w_load = LD_BUBBLE;
        else begin
          w_load = LD_CAPTURE;
          if (halt) w_next_state = ST_HALTED;
        end
      end
      ST_HALTED: w_load = LD_HALT_DRAIN;
      default:   w_load = LD_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid      <= 1'b0;
      m_result     <= '0;
      m_store_data <= '0;
      m_rd         <= '0;
      m_reg_wen    <= 1'b0;
      m_mem_wen    <= 1'b0;
      m_mem_ren    <= 1'b0;
      m_halt       <= 1'b0;
      m_br_taken   <= 1'b0;
      m_br_target  <= '0;
      m_ofl        <= 1'b0;
    end else begin
      case (w_load)
        LD_CAPTURE: begin
          m_valid      <= 1'b1;
          m_result     <= w_result;
          m_store_data <= store_data;
          m_rd         <= rd;
          m_reg_wen    <= reg_wen;
          m_mem_wen    <= mem_wen;
          m_mem_ren    <= mem_ren;
          m_halt       <= halt;
          m_br_taken   <= w_taken;
          m_br_target  <= br_target_in;
          m_ofl        <= alu_ofl & ~set_en;
        end
        LD_BUBBLE, LD_HALT_DRAIN: begin
          m_valid    <= 1'b0;
          m_reg_wen  <= 1'b0;
          m_mem_wen  <= 1'b0;
          m_mem_ren  <= 1'b0;
          m_halt     <= (w_load == LD_HALT_DRAIN);
          m_br_taken <= 1'b0;
          m_ofl      <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed self-checking bench for ex_mem_stage
module tb_ex_mem_stage;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ex_valid, stall, flush;
  logic [W-1:0] alu_out;
  logic         alu_zero, alu_ofl, alu_cf;
  logic         set_en;
  logic [1:0]   set_op;
  logic         br_en;
  logic [1:0]   br_cond;
  logic [W-1:0] rs_val, br_target_in, store_data;
  logic [2:0]   rd;
  logic         reg_wen, mem_wen, mem_ren, halt;
  logic         m_valid;
  logic [W-1:0] m_result, m_store_data;
  logic [2:0]   m_rd;
  logic         m_reg_wen, m_mem_wen, m_mem_ren, m_halt, m_br_taken;
  logic [W-1:0] m_br_target;
  logic         m_ofl;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_stage #(.OPERAND_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall), .flush(flush),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_ofl(alu_ofl), .alu_cf(alu_cf),
    .set_en(set_en), .set_op(set_op), .br_en(br_en), .br_cond(br_cond),
    .rs_val(rs_val), .br_target_in(br_target_in), .store_data(store_data),
    .rd(rd), .reg_wen(reg_wen), .mem_wen(mem_wen), .mem_ren(mem_ren), .halt(halt),
    .m_valid(m_valid), .m_result(m_result), .m_store_data(m_store_data),
    .m_rd(m_rd), .m_reg_wen(m_reg_wen), .m_mem_wen(m_mem_wen),
    .m_mem_ren(m_mem_ren), .m_halt(m_halt), .m_br_taken(m_br_taken),
    .m_br_target(m_br_target), .m_ofl(m_ofl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; stall = 0; flush = 0;
    alu_out = '0; alu_zero = 0; alu_ofl = 0; alu_cf = 0;
    set_en = 0; set_op = 2'b00; br_en = 0; br_cond = 2'b00;
    rs_val = '0; br_target_in = '0; store_data = '0; rd = '0;
    reg_wen = 0; mem_wen = 0; mem_ren = 0; halt = 0;
  endtask

  initial begin
    idle_inputs();
    #1 rst = 1;
    #1;
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_result", {16'd0, m_result}, 32'd0);
    check("rst_halt", {31'd0, m_halt}, 32'd0);
    step(); step();
    rst = 0;

    // SLT with negative difference
    ex_valid = 1; alu_out = 16'hFFFF; set_en = 1; set_op = 2'b01; alu_ofl = 0;
    step();
    check("slt_result", {16'd0, m_result}, 32'h0001);
    check("slt_valid", {31'd0, m_valid}, 32'd1);

    // Overflowed SLT, then SEQ on same operands
    alu_out = 16'h7FFF; alu_ofl = 1; set_op = 2'b01;
    step();
    check("slt_ofl_result", {16'd0, m_result}, 32'h0001);
    check("slt_ofl_mofl", {31'd0, m_ofl}, 32'd0);
    set_op = 2'b00;
    step();
    check("seq_result", {16'd0, m_result}, 32'h0000);

    // SLE on equal operands, SCO with carry
    alu_out = 16'h0000; alu_ofl = 0; alu_zero = 1; set_op = 2'b10;
    step();
    check("sle_result", {16'd0, m_result}, 32'h0001);
    alu_zero = 0; alu_cf = 1; set_op = 2'b11; alu_out = 16'h8001;
    step();
    check("sco_result", {16'd0, m_result}, 32'h0001);

    // Plain ALU result carries overflow flag through
    set_en = 0; alu_cf = 0; alu_out = 16'h8000; alu_ofl = 1;
    step();
    check("add_result", {16'd0, m_result}, 32'h8000);
    check("add_ofl", {31'd0, m_ofl}, 32'd1);

    // Branches
    alu_ofl = 0; br_en = 1; br_cond = 2'b10; rs_val = 16'h8000; br_target_in = 16'h0040;
    step();
    check("bltz_taken", {31'd0, m_br_taken}, 32'd1);
    check("bltz_target", {16'd0, m_br_target}, 32'h0040);
    br_cond = 2'b11;
    step();
    check("bgez_taken", {31'd0, m_br_taken}, 32'd0);
    br_cond = 2'b00; rs_val = 16'h0000;
    step();
    check("beqz_taken", {31'd0, m_br_taken}, 32'd1);
    br_cond = 2'b01;
    step();
    check("bnez_zero_taken", {31'd0, m_br_taken}, 32'd0);
    br_en = 0; br_cond = 2'b00;
    step();
    check("br_dis_taken", {31'd0, m_br_taken}, 32'd0);

    // Store fields and enables
    alu_out = 16'h0A0A; store_data = 16'hBEEF; rd = 3'd5; reg_wen = 1; mem_wen = 1;
    step();
    check("st_data", {16'd0, m_store_data}, 32'h0000BEEF);
    check("st_rd", {29'd0, m_rd}, 32'd5);
    check("st_mem_wen", {31'd0, m_mem_wen}, 32'd1);

    // Stall holds for three cycles despite changing inputs
    stall = 1; alu_out = 16'h1111; rd = 3'd2; mem_wen = 0; mem_ren = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_result", {16'd0, m_result}, 32'h0A0A);
      check("stall_rd", {29'd0, m_rd}, 32'd5);
      check("stall_valid", {31'd0, m_valid}, 32'd1);
      alu_out = alu_out + 16'h1111;
    end

    // Flush beats stall; data fields stay
    flush = 1;
    step();
    check("flush_valid", {31'd0, m_valid}, 32'd0);
    check("flush_reg_wen", {31'd0, m_reg_wen}, 32'd0);
    check("flush_result", {16'd0, m_result}, 32'h0A0A);
    flush = 0; stall = 0; mem_ren = 0; reg_wen = 1;

    // Invalid EX loads bubble
    ex_valid = 0;
    step();
    check("bubble_valid", {31'd0, m_valid}, 32'd0);
    check("bubble_reg_wen", {31'd0, m_reg_wen}, 32'd0);

    // Halt behind a stall is not captured
    ex_valid = 1; halt = 1; stall = 1; alu_out = 16'hABCD;
    step();
    check("stall_halt", {31'd0, m_halt}, 32'd0);
    stall = 0;
    step();
    check("halt_halt", {31'd0, m_halt}, 32'd1);
    check("halt_valid", {31'd0, m_valid}, 32'd1);
    halt = 0; alu_out = 16'h5555; reg_wen = 1;
    step();
    check("halted_valid", {31'd0, m_valid}, 32'd0);
    check("halted_halt", {31'd0, m_halt}, 32'd1);
    check("halted_reg_wen", {31'd0, m_reg_wen}, 32'd0);
    check("halted_result", {16'd0, m_result}, 32'h0000ABCD);
    flush = 1;
    step();
    check("halted_flush_halt", {31'd0, m_halt}, 32'd1);
    flush = 0;
    step();
    check("halted_still", {31'd0, m_halt}, 32'd1);

    // Async reset mid-cycle, then resume
    rst = 1;
    #2;
    check("arst_halt", {31'd0, m_halt}, 32'd0);
    check("arst_result", {16'd0, m_result}, 32'd0);
    rst = 0;
    alu_out = 16'h1234; ex_valid = 1; reg_wen = 1;
    step();
    check("resume_result", {16'd0, m_result}, 32'h1234);
    check("resume_valid", {31'd0, m_valid}, 32'd1);
    check("resume_halt", {31'd0, m_halt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
